error_accumulator: RTL and testbench
====================================

Name: error_accumulator

Overview:
- Downstream consumer of the error-checker stage in the linear-regression datapath.
- Takes one signed fixed-point error sample per error_valid pulse, i.e. the checker's done strobe with error_bus.
- Accumulates squared error over 2**N_LOG2 samples and produces the mean squared error (MSE).
- Compares the MSE against a threshold so the training controller can decide whether to stop iterating.

Parameters:
- DATA_W, 20: width of error_bus, mse_bus and threshold_bus.
- FRAC_W, 10: fractional bits of the fixed-point format (Q9.10 signed error; Q10.10 unsigned MSE).
- N_LOG2, 2: log2 of samples per epoch; epoch length N = 2**N_LOG2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- start  in  1  one-cycle pulse; begins a new epoch. Honoured only in IDLE.
- error_bus  in  DATA_W  signed two's-complement error sample.
- error_valid  in  1  error_bus is valid this cycle.
- threshold_bus  in  DATA_W  unsigned MSE threshold; sampled in FINISH.
- mse_bus  out  DATA_W  unsigned saturated MSE of the last completed epoch.
- converged  out  1  high when mse_bus <= threshold_bus; held until the next epoch completes.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when mse_bus and converged update.

Behaviour:
- Reset values:
  - State = IDLE; accumulator = 0; sample counter = 0.
  - mse_bus = 0, converged = 0, done = 0, ready = 1.
- States:
  - IDLE: ready=1.
    - start=1 → clear accumulator and counter → ACCUM.
    - error_valid is ignored in IDLE, including the cycle in which start=1.
  - ACCUM: ready=0.
    - On each cycle with error_valid=1, add sq to the accumulator and increment the counter.
    - When error_valid=1 and counter = N-1, the N-th sample is added that cycle → FINISH.
    - Cycles with error_valid=0 stall; there is no timeout.
  - FINISH: one cycle.
    - Register mse_bus = sat(acc >> N_LOG2).
    - Register converged = (mse_bus_next <= threshold_bus).
    - Assert done=1 → IDLE.
- Arithmetic:
  - sq = (e*e) >> FRAC_W, computed as a full 2*DATA_W product, always non-negative.
  - The largest case is e = -2**(DATA_W-1): the square is 2**38, and sq is 2**28 for the defaults.
  - sq width is 2*DATA_W-FRAC_W (30 bits); accumulator width is that plus N_LOG2 (32 bits). Overflow is impossible.
  - sat(): if the shifted result exceeds 2**DATA_W-1, output all-ones (0xFFFFF).
- Latency: done is asserted the cycle after the N-th accepted sample's clock edge.
- start pulses in ACCUM or FINISH are ignored; they are not queued.
- error_valid in FINISH is dropped.
- mse_bus and converged hold their values while IDLE and ACCUM, until the next FINISH.
- rst low at any time, including mid-epoch, aborts the epoch and restores all reset values asynchronously.

Decomposition:
- Shared package holds:
  - DATA_W and FRAC_W, common with the error-checker datapath.
  - State encoding constants: IDLE, ACCUM, FINISH.
- One sub-module, error_squarer:
  - Combinational, DATA_W signed in, 2*DATA_W-FRAC_W unsigned out.
  - Can be reused if the squarer is later pipelined.
- The controller FSM and the accumulator/counter datapath live in error_accumulator itself.

Test Plan:
- Reset: hold rst=0 mid-ACCUM after 2 samples → mse_bus=0x00000, converged=0, ready=1. After release, a fresh start plus 4 samples of 0x00400 → mse_bus=0x00400.
- Uniform epoch: start, then 4 samples of 0x00400 (1.0) with threshold 0x00400 → done one cycle after the 4th sample; mse_bus=0x00400; converged=1.
- Mixed signs: samples 0x00400, 0xFFC00, 0x00800, 0xFF800 (1, -1, 2, -2), threshold 0x00800 → mse_bus=0x00A00 (2.5); converged=0.
- Saturation: 4 samples of 0x80000 → mse_bus=0xFFFFF; with threshold 0xFFFFF, converged=1.
- Stalls and ignored inputs:
  - error_valid gaps of 0 to 3 cycles between samples → result identical to the back-to-back run.
  - start pulsed during ACCUM → no restart, same mse_bus.
  - error_valid asserted together with start in IDLE → not counted.
- Back-to-back epochs: start on the cycle after done, then 4 samples of 0x00000 → mse_bus=0x00000 and converged=1. The previous result stays on mse_bus until this FINISH.

Source files
------------

// File: rtl/error_accumulator_pkg.sv
// rtl/error_accumulator_pkg.sv - shared widths and FSM encoding for the error accumulator
package error_accumulator_pkg;

  // Fixed-point format shared with the error-checker datapath
  localparam int DATA_W = 20;
  localparam int FRAC_W = 10;

  // Width of one scaled squared error sample
  localparam int SQ_W = 2 * DATA_W - FRAC_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/error_squarer.sv
// rtl/error_squarer.sv - combinational fixed-point square of a signed error sample
module error_squarer
  import error_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] error_bus,
  output logic [SQ_W-1:0]   sq
);

  // Sign-extend to the full product width so the multiply keeps every bit
  logic signed [2*DATA_W-1:0] e_ext;
  logic signed [2*DATA_W-1:0] prod;

  assign e_ext = {{DATA_W{error_bus[DATA_W-1]}}, error_bus};

  // A square is never negative, so the top bit of prod is always clear and
  // even the most negative input (-2**(DATA_W-1)) fits without wrapping.
  assign prod = e_ext * e_ext;

  // Drop the extra fractional bits to return to the input's binary point
  assign sq = SQ_W'(prod >>> FRAC_W);

endmodule

// File: rtl/error_accumulator.sv
// rtl/error_accumulator.sv - mean squared error over an epoch with threshold compare
module error_accumulator
  import error_accumulator_pkg::*;
#(
  parameter int N_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] error_bus,
  input  logic              error_valid,
  input  logic [DATA_W-1:0] threshold_bus,
  output logic [DATA_W-1:0] mse_bus,
  output logic              converged,
  output logic              ready,
  output logic              done
);

  // Room for N full-scale squares, so the sum can never wrap
  localparam int ACC_W = SQ_W + N_LOG2;
  localparam int CNT_W = (N_LOG2 > 0) ? N_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << N_LOG2) - 1);
  localparam logic [ACC_W-1:0] MSE_MAX = ACC_W'((64'd1 << DATA_W) - 64'd1);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [SQ_W-1:0]   sq;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  mse_shift;
  logic [DATA_W-1:0] mse_next;

  error_squarer u_squarer (
    .error_bus (error_bus),
    .sq        (sq)
  );

  // Running sum including the current sample, and its mean over the epoch
  assign acc_sum   = acc + ACC_W'(sq);
  assign mse_shift = acc_sum >> N_LOG2;

  // Clamp the mean to the largest value mse_bus can carry
  always_comb begin
    mse_next = mse_shift[DATA_W-1:0];
    if (mse_shift > MSE_MAX) begin
      mse_next = '1;
    end
  end

  // Controller FSM with accumulator/counter datapath and registered outputs.
  // The result is captured on the edge that accepts the last sample, so
  // mse_bus, converged and done are all valid together during FINISH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      mse_bus   <= '0;
      converged <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (error_valid) begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              mse_bus   <= mse_next;
              converged <= (mse_next <= threshold_bus);
              done      <= 1'b1;
              state     <= FINISH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_error_accumulator.sv
// tb/tb_error_accumulator.sv - randomized self-checking bench for error_accumulator
module tb_error_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [19:0] error_bus = '0;
  logic        error_valid = 1'b0;
  logic [19:0] threshold_bus = '0;
  logic [19:0] mse_bus;
  logic        converged;
  logic        ready;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [19:0] smp [4];
  int          gap [4];
  logic [19:0] prev_mse = '0;
  logic        prev_conv = 1'b0;
  logic [19:0] last_mse;
  logic        last_conv;

  error_accumulator #(.N_LOG2(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .error_bus     (error_bus),
    .error_valid   (error_valid),
    .threshold_bus (threshold_bus),
    .mse_bus       (mse_bus),
    .converged     (converged),
    .ready         (ready),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Reference: mean of floor(e*e / 2**10) over four samples, clamped to 20 bits
  function automatic logic [19:0] model_mse();
    longint sum;
    longint e;
    longint m;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      e = longint'($signed(smp[i]));
      sum = sum + (e * e) / 1024;
    end
    m = sum / 4;
    if (m > 64'sd1048575) m = 64'sd1048575;
    return m[19:0];
  endfunction

  function automatic logic [19:0] rand_sample();
    logic [19:0] v;
    case ($urandom_range(0, 4))
      0: v = 20'($urandom);
      1: v = 20'($urandom_range(0, 4095));
      2: v = 20'(-$urandom_range(0, 4095));
      3: v = 20'h80000;
      default: v = 20'h7FFFF;
    endcase
    return v;
  endfunction

  // Drive one epoch from smp[]/gap[], check hold, latency, result and pulse width
  task automatic run_epoch(input logic [19:0] thr, input bit use_gaps, input bit poke_start);
    logic [19:0] exp_mse;
    logic        exp_conv;
    int          n;
    exp_mse  = model_mse();
    exp_conv = (exp_mse <= thr);
    threshold_bus = thr;
    // error_valid alongside start must not be counted
    start = 1'b1;
    error_valid = 1'b1;
    error_bus = 20'h7FFFF;
    @(negedge clk);
    start = 1'b0;
    error_valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_in_accum: got %b want 0", ready);
    end
    for (int i = 0; i < 4; i++) begin
      int g;
      g = use_gaps ? gap[i] : 0;
      if (poke_start && i == 2 && g == 0) g = 1;
      for (int k = 0; k < g; k++) begin
        error_valid = 1'b0;
        error_bus = 20'h80000;
        if (poke_start && i == 2) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      error_bus = smp[i];
      error_valid = 1'b1;
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (mse_bus !== prev_mse || converged !== prev_conv) begin
          failures++;
          $display("FAIL hold_mid_epoch: got %h/%b want %h/%b", mse_bus, converged, prev_mse, prev_conv);
        end
      end
    end
    // keep a junk sample valid during FINISH; it must be dropped
    error_bus = 20'h7FFFF;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_latency: got %b want 1 one cycle after last sample", done);
    end
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      error_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout: got %b want 1 within 8 cycles", done);
    end
    last_mse  = mse_bus;
    last_conv = converged;
    checks++;
    if (mse_bus !== exp_mse) begin
      failures++;
      $display("FAIL mse_bus: got %h want %h (thr %h)", mse_bus, exp_mse, thr);
    end
    checks++;
    if (converged !== exp_conv) begin
      failures++;
      $display("FAIL converged: got %b want %b (mse %h thr %h)", converged, exp_conv, exp_mse, thr);
    end
    @(negedge clk);
    error_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL after_done: got done=%b ready=%b want done=0 ready=1", done, ready);
    end
    prev_mse  = exp_mse;
    prev_conv = exp_conv;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (mse_bus !== 20'h0 || converged !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got mse=%h conv=%b ready=%b done=%b want 0/0/1/0", mse_bus, converged, ready, done);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) smp[i] = 20'h00400;
    run_epoch(20'h00400, 1'b0, 1'b0);
    // abort mid-epoch after two samples
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    error_bus = 20'h7FFFF;
    error_valid = 1'b1;
    repeat (2) @(negedge clk);
    error_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mse_bus !== 20'h0 || converged !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got mse=%h conv=%b ready=%b done=%b want 0/0/1/0", mse_bus, converged, ready, done);
    end
    @(negedge clk);
    rst = 1'b1;
    prev_mse = '0;
    prev_conv = 1'b0;
    @(negedge clk);
    run_epoch(20'h00400, 1'b0, 1'b0);
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 4; i++) smp[i] = 20'h00400;
    run_epoch(20'h00400, 1'b0, 1'b0);
  endtask

  task automatic test_mixed_signs();
    smp[0] = 20'h00400;
    smp[1] = 20'hFFC00;
    smp[2] = 20'h00800;
    smp[3] = 20'hFF800;
    run_epoch(20'h00800, 1'b0, 1'b0);
    checks++;
    if (last_mse !== 20'h00A00 || last_conv !== 1'b0) begin
      failures++;
      $display("FAIL mixed_literal: got %h/%b want 00a00/0", last_mse, last_conv);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) smp[i] = 20'h80000;
    run_epoch(20'hFFFFF, 1'b0, 1'b0);
    checks++;
    if (last_mse !== 20'hFFFFF || last_conv !== 1'b1) begin
      failures++;
      $display("FAIL sat_literal: got %h/%b want fffff/1", last_mse, last_conv);
    end
  endtask

  task automatic test_stalls();
    logic [19:0] ref_mse;
    logic [19:0] exp;
    logic [19:0] thr;
    for (int i = 0; i < 4; i++) smp[i] = 20'($urandom_range(0, 8191) - 4096);
    run_epoch(20'h00300, 1'b0, 1'b0);
    ref_mse = last_mse;
    for (int i = 0; i < 4; i++) gap[i] = $urandom_range(0, 3);
    run_epoch(20'h00300, 1'b1, 1'b1);
    checks++;
    if (last_mse !== ref_mse) begin
      failures++;
      $display("FAIL stall_vs_b2b: got %h want %h", last_mse, ref_mse);
    end
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 4; i++) begin
        smp[i] = rand_sample();
        gap[i] = $urandom_range(0, 3);
      end
      exp = model_mse();
      case ($urandom_range(0, 3))
        0: thr = exp;
        1: thr = exp - 20'd1;
        2: thr = exp + 20'd1;
        default: thr = 20'($urandom);
      endcase
      run_epoch(thr, 1'b1, ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic test_back_to_back();
    smp[0] = 20'h00C00;
    smp[1] = 20'hFF400;
    smp[2] = 20'h00200;
    smp[3] = 20'h00000;
    run_epoch(20'h00100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) smp[i] = 20'h00000;
    run_epoch(20'h00010, 1'b0, 1'b0);
    checks++;
    if (last_mse !== 20'h00000 || last_conv !== 1'b1) begin
      failures++;
      $display("FAIL b2b_literal: got %h/%b want 00000/1", last_mse, last_conv);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_mixed_signs();
    test_saturation();
    test_stalls();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
